// File: rtl/id_exe_pkg.sv
// Shared widths, the NOP opcode, bubble values for each field, and the
// operand-select mode used by the ID->EXE pipeline register.
package id_exe_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_IMM_W  = 12;
  localparam int unsigned DEF_OPC_W  = 5;
  localparam int unsigned DEF_REG_W  = 4;
  localparam int unsigned DEF_ICMD_W = 3;
  localparam int unsigned DEF_CNT_W  = 16;

  localparam logic [DEF_OPC_W-1:0] NOP_OPCODE = 5'd0;

  // A bubble is an all-zero instruction carrying the NOP opcode.
  localparam logic                  BUBBLE_VALID = 1'b0;
  localparam logic [DEF_DATA_W-1:0] BUBBLE_A     = 32'h0000_0000;
  localparam logic [DEF_DATA_W-1:0] BUBBLE_B     = 32'h0000_0000;
  localparam logic [DEF_IMM_W-1:0]  BUBBLE_IMM   = 12'h000;
  localparam logic [DEF_REG_W-1:0]  BUBBLE_RD    = 4'd0;
  localparam logic [DEF_REG_W-1:0]  BUBBLE_RN    = 4'd0;
  localparam logic [DEF_REG_W-1:0]  BUBBLE_RM    = 4'd0;
  localparam logic [DEF_ICMD_W-1:0] BUBBLE_ICMD  = 3'd0;
  localparam logic                  BUBBLE_S     = 1'b0;

  typedef enum logic [1:0] {
    SEL_LOAD   = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_BUBBLE = 2'd2
  } sel_mode_e;

endpackage

// File: rtl/id_exe_operand_sel.sv
// Next-value select for one EXE operand: write-back refresh while holding,
// optional same-cycle write-back bypass while loading, zero for a bubble.
module id_exe_operand_sel
  import id_exe_pkg::*;
#(
  parameter int unsigned        DATA_W     = DEF_DATA_W,
  parameter int unsigned        REG_W      = DEF_REG_W,
  parameter bit                 WB_BYPASS  = 1'b1,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0
) (
  input  logic [DATA_W-1:0] held_val_i,
  input  logic [REG_W-1:0]  held_reg_i,
  input  logic [DATA_W-1:0] in_val_i,
  input  logic [REG_W-1:0]  in_reg_i,
  input  logic              wb_en_i,
  input  logic [REG_W-1:0]  wb_rd_num_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  sel_mode_e         mode_i,
  input  logic              valid_i,
  output logic [DATA_W-1:0] next_val_o
);

  // In hold mode valid_i is the held-valid flag; in load mode it is ID valid.
  always_comb begin
    next_val_o = held_val_i;
    case (mode_i)
      SEL_HOLD: begin
        if (valid_i && wb_en_i && (wb_rd_num_i == held_reg_i)) begin
          next_val_o = wb_data_i;
        end else begin
          next_val_o = held_val_i;
        end
      end
      SEL_LOAD: begin
        if (!valid_i) begin
          next_val_o = BUBBLE_VAL;
        end else if (WB_BYPASS && wb_en_i && (wb_rd_num_i == in_reg_i)) begin
          next_val_o = wb_data_i;
        end else begin
          next_val_o = in_val_i;
        end
      end
      SEL_BUBBLE: next_val_o = BUBBLE_VAL;
      default:    next_val_o = BUBBLE_VAL;
    endcase
  end

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register with valid tracking, stall/flush, write-back
// operand refresh and bypass, and a saturating stall-cycle counter.
module id_exe_stage_reg #(
  parameter int unsigned       DATA_W     = id_exe_pkg::DEF_DATA_W,
  parameter int unsigned       IMM_W      = id_exe_pkg::DEF_IMM_W,
  parameter int unsigned       OPC_W      = id_exe_pkg::DEF_OPC_W,
  parameter int unsigned       REG_W      = id_exe_pkg::DEF_REG_W,
  parameter int unsigned       ICMD_W     = id_exe_pkg::DEF_ICMD_W,
  parameter logic [OPC_W-1:0]  NOP_OPCODE = OPC_W'(id_exe_pkg::NOP_OPCODE),
  parameter bit                WB_BYPASS  = 1'b1,
  parameter int unsigned       CNT_W      = id_exe_pkg::DEF_CNT_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ID_Valid,
  input  logic [DATA_W-1:0] ID_A,
  input  logic [DATA_W-1:0] ID_B,
  input  logic [IMM_W-1:0]  ID_immed,
  input  logic [OPC_W-1:0]  ID_Opcode,
  input  logic [REG_W-1:0]  ID_Rd_num,
  input  logic [REG_W-1:0]  ID_Rn_num,
  input  logic [REG_W-1:0]  ID_Rm_num,
  input  logic [ICMD_W-1:0] ID_I_cmd,
  input  logic              ID_S,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              WB_En,
  input  logic [REG_W-1:0]  WB_Rd_num,
  input  logic [DATA_W-1:0] WB_Data,
  output logic              EXE_Valid,
  output logic [DATA_W-1:0] EXE_A,
  output logic [DATA_W-1:0] EXE_B,
  output logic [IMM_W-1:0]  EXE_immed,
  output logic [OPC_W-1:0]  EXE_Opcode,
  output logic [REG_W-1:0]  EXE_Rd_num,
  output logic [REG_W-1:0]  EXE_Rn_num,
  output logic [REG_W-1:0]  EXE_Rm_num,
  output logic [ICMD_W-1:0] EXE_I_cmd,
  output logic              EXE_S,
  output logic [CNT_W-1:0]  EXE_Stall_cnt
);

  import id_exe_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  sel_mode_e         mode_s;
  logic              sel_valid_s;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [REG_W-1:0]  rn_q, rn_d;
  logic [REG_W-1:0]  rm_q, rm_d;
  logic [ICMD_W-1:0] icmd_q, icmd_d;
  logic              s_q, s_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Flush beats stall, stall beats load.
  always_comb begin
    mode_s      = SEL_LOAD;
    sel_valid_s = ID_Valid;
    if (Flush) begin
      mode_s      = SEL_BUBBLE;
      sel_valid_s = 1'b0;
    end else if (Stall) begin
      mode_s      = SEL_HOLD;
      sel_valid_s = valid_q;
    end else begin
      mode_s      = SEL_LOAD;
      sel_valid_s = ID_Valid;
    end
  end

  id_exe_operand_sel #(
    .DATA_W    (DATA_W),
    .REG_W     (REG_W),
    .WB_BYPASS (WB_BYPASS),
    .BUBBLE_VAL(DATA_W'(BUBBLE_A))
  ) u_sel_a (
    .held_val_i (a_q),
    .held_reg_i (rn_q),
    .in_val_i   (ID_A),
    .in_reg_i   (ID_Rn_num),
    .wb_en_i    (WB_En),
    .wb_rd_num_i(WB_Rd_num),
    .wb_data_i  (WB_Data),
    .mode_i     (mode_s),
    .valid_i    (sel_valid_s),
    .next_val_o (a_d)
  );

  id_exe_operand_sel #(
    .DATA_W    (DATA_W),
    .REG_W     (REG_W),
    .WB_BYPASS (WB_BYPASS),
    .BUBBLE_VAL(DATA_W'(BUBBLE_B))
  ) u_sel_b (
    .held_val_i (b_q),
    .held_reg_i (rm_q),
    .in_val_i   (ID_B),
    .in_reg_i   (ID_Rm_num),
    .wb_en_i    (WB_En),
    .wb_rd_num_i(WB_Rd_num),
    .wb_data_i  (WB_Data),
    .mode_i     (mode_s),
    .valid_i    (sel_valid_s),
    .next_val_o (b_d)
  );

  // Non-operand fields: hold, capture, or bubble.
  always_comb begin
    valid_d = BUBBLE_VALID;
    imm_d   = IMM_W'(BUBBLE_IMM);
    opc_d   = NOP_OPCODE;
    rd_d    = REG_W'(BUBBLE_RD);
    rn_d    = REG_W'(BUBBLE_RN);
    rm_d    = REG_W'(BUBBLE_RM);
    icmd_d  = ICMD_W'(BUBBLE_ICMD);
    s_d     = BUBBLE_S;
    case (mode_s)
      SEL_HOLD: begin
        valid_d = valid_q;
        imm_d   = imm_q;
        opc_d   = opc_q;
        rd_d    = rd_q;
        rn_d    = rn_q;
        rm_d    = rm_q;
        icmd_d  = icmd_q;
        s_d     = s_q;
      end
      SEL_LOAD: begin
        if (ID_Valid) begin
          valid_d = 1'b1;
          imm_d   = ID_immed;
          opc_d   = ID_Opcode;
          rd_d    = ID_Rd_num;
          rn_d    = ID_Rn_num;
          rm_d    = ID_Rm_num;
          icmd_d  = ID_I_cmd;
          s_d     = ID_S;
        end else begin
          valid_d = BUBBLE_VALID;
          opc_d   = NOP_OPCODE;
        end
      end
      SEL_BUBBLE: begin
        valid_d = BUBBLE_VALID;
        opc_d   = NOP_OPCODE;
      end
      default: begin
        valid_d = BUBBLE_VALID;
        opc_d   = NOP_OPCODE;
      end
    endcase
  end

  // Counts only stalls that actually hold a live instruction; never wraps.
  always_comb begin
    if (Stall && !Flush && valid_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stage state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      opc_q   <= NOP_OPCODE;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      icmd_q  <= '0;
      s_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      opc_q   <= opc_d;
      rd_q    <= rd_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      icmd_q  <= icmd_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

  assign EXE_Valid     = valid_q;
  assign EXE_A         = a_q;
  assign EXE_B         = b_q;
  assign EXE_immed     = imm_q;
  assign EXE_Opcode    = opc_q;
  assign EXE_Rd_num    = rd_q;
  assign EXE_Rn_num    = rn_q;
  assign EXE_Rm_num    = rm_q;
  assign EXE_I_cmd     = icmd_q;
  assign EXE_S         = s_q;
  assign EXE_Stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Scoreboard bench: three instances (default, no WB bypass, 3-bit counter)
// share stimulus; expected post-edge state is queued and checked at negedge.
module tb_id_exe_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [11:0] imm;
    logic [4:0]  opc;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [2:0]  icmd;
    logic        s;
    logic [15:0] cnt;
  } rec_t;

  typedef struct packed {
    rec_t        m;
    logic [31:0] a_nb;
    logic [31:0] b_nb;
    logic [15:0] cnt_sat;
  } exp_t;

  logic        Clk, Rst_n;
  logic        ID_Valid, ID_S, Stall, Flush, WB_En;
  logic [31:0] ID_A, ID_B, WB_Data;
  logic [11:0] ID_immed;
  logic [4:0]  ID_Opcode;
  logic [3:0]  ID_Rd_num, ID_Rn_num, ID_Rm_num, WB_Rd_num;
  logic [2:0]  ID_I_cmd;

  logic        m_valid, n_valid, t_valid, m_s, n_s, t_s;
  logic [31:0] m_a, m_b, n_a, n_b, t_a, t_b;
  logic [11:0] m_imm, n_imm, t_imm;
  logic [4:0]  m_opc, n_opc, t_opc;
  logic [3:0]  m_rd, m_rn, m_rm, n_rd, n_rn, n_rm, t_rd, t_rn, t_rm;
  logic [2:0]  m_icmd, n_icmd, t_icmd;
  logic [15:0] m_cnt, n_cnt;
  logic [2:0]  t_cnt;

  rec_t o_main, o_nb, o_sat;
  exp_t q[$];
  exp_t e, mon_x;
  int   errors = 0;
  int   checks = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  id_exe_stage_reg dut (
    .Clk(Clk), .Rst_n(Rst_n), .ID_Valid(ID_Valid), .ID_A(ID_A), .ID_B(ID_B),
    .ID_immed(ID_immed), .ID_Opcode(ID_Opcode), .ID_Rd_num(ID_Rd_num),
    .ID_Rn_num(ID_Rn_num), .ID_Rm_num(ID_Rm_num), .ID_I_cmd(ID_I_cmd), .ID_S(ID_S),
    .Stall(Stall), .Flush(Flush), .WB_En(WB_En), .WB_Rd_num(WB_Rd_num), .WB_Data(WB_Data),
    .EXE_Valid(m_valid), .EXE_A(m_a), .EXE_B(m_b), .EXE_immed(m_imm), .EXE_Opcode(m_opc),
    .EXE_Rd_num(m_rd), .EXE_Rn_num(m_rn), .EXE_Rm_num(m_rm), .EXE_I_cmd(m_icmd),
    .EXE_S(m_s), .EXE_Stall_cnt(m_cnt));

  id_exe_stage_reg #(.WB_BYPASS(1'b0)) dut_nb (
    .Clk(Clk), .Rst_n(Rst_n), .ID_Valid(ID_Valid), .ID_A(ID_A), .ID_B(ID_B),
    .ID_immed(ID_immed), .ID_Opcode(ID_Opcode), .ID_Rd_num(ID_Rd_num),
    .ID_Rn_num(ID_Rn_num), .ID_Rm_num(ID_Rm_num), .ID_I_cmd(ID_I_cmd), .ID_S(ID_S),
    .Stall(Stall), .Flush(Flush), .WB_En(WB_En), .WB_Rd_num(WB_Rd_num), .WB_Data(WB_Data),
    .EXE_Valid(n_valid), .EXE_A(n_a), .EXE_B(n_b), .EXE_immed(n_imm), .EXE_Opcode(n_opc),
    .EXE_Rd_num(n_rd), .EXE_Rn_num(n_rn), .EXE_Rm_num(n_rm), .EXE_I_cmd(n_icmd),
    .EXE_S(n_s), .EXE_Stall_cnt(n_cnt));

  id_exe_stage_reg #(.CNT_W(3)) dut_sat (
    .Clk(Clk), .Rst_n(Rst_n), .ID_Valid(ID_Valid), .ID_A(ID_A), .ID_B(ID_B),
    .ID_immed(ID_immed), .ID_Opcode(ID_Opcode), .ID_Rd_num(ID_Rd_num),
    .ID_Rn_num(ID_Rn_num), .ID_Rm_num(ID_Rm_num), .ID_I_cmd(ID_I_cmd), .ID_S(ID_S),
    .Stall(Stall), .Flush(Flush), .WB_En(WB_En), .WB_Rd_num(WB_Rd_num), .WB_Data(WB_Data),
    .EXE_Valid(t_valid), .EXE_A(t_a), .EXE_B(t_b), .EXE_immed(t_imm), .EXE_Opcode(t_opc),
    .EXE_Rd_num(t_rd), .EXE_Rn_num(t_rn), .EXE_Rm_num(t_rm), .EXE_I_cmd(t_icmd),
    .EXE_S(t_s), .EXE_Stall_cnt(t_cnt));

  assign o_main = {m_valid, m_a, m_b, m_imm, m_opc, m_rd, m_rn, m_rm, m_icmd, m_s, m_cnt};
  assign o_nb   = {n_valid, n_a, n_b, n_imm, n_opc, n_rd, n_rn, n_rm, n_icmd, n_s, n_cnt};
  assign o_sat  = {t_valid, t_a, t_b, t_imm, t_opc, t_rd, t_rn, t_rm, t_icmd, t_s, 13'd0, t_cnt};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_rec(input string tag, input rec_t act, input rec_t exp);
    chk({tag, ".valid"}, 32'(act.valid), 32'(exp.valid));
    chk({tag, ".A"},     act.a,          exp.a);
    chk({tag, ".B"},     act.b,          exp.b);
    chk({tag, ".immed"}, 32'(act.imm),   32'(exp.imm));
    chk({tag, ".opc"},   32'(act.opc),   32'(exp.opc));
    chk({tag, ".rd"},    32'(act.rd),    32'(exp.rd));
    chk({tag, ".rn"},    32'(act.rn),    32'(exp.rn));
    chk({tag, ".rm"},    32'(act.rm),    32'(exp.rm));
    chk({tag, ".icmd"},  32'(act.icmd),  32'(exp.icmd));
    chk({tag, ".S"},     32'(act.s),     32'(exp.s));
    chk({tag, ".cnt"},   32'(act.cnt),   32'(exp.cnt));
  endtask

  task automatic cmp_all(input exp_t x);
    rec_t r;
    cmp_rec("main", o_main, x.m);
    r = x.m; r.a = x.a_nb; r.b = x.b_nb;
    cmp_rec("nobyp", o_nb, r);
    r = x.m; r.cnt = x.cnt_sat;
    cmp_rec("sat", o_sat, r);
  endtask

  function automatic rec_t mk(logic v, logic [31:0] a, logic [31:0] b, logic [11:0] imm,
                              logic [4:0] opc, logic [3:0] rd, logic [3:0] rn, logic [3:0] rm,
                              logic [2:0] icmd, logic s, logic [15:0] cnt);
    rec_t r;
    r = {v, a, b, imm, opc, rd, rn, rm, icmd, s, cnt};
    return r;
  endfunction

  function automatic exp_t mkx(rec_t m, logic [31:0] a_nb, logic [31:0] b_nb, logic [15:0] cs);
    exp_t x;
    x.m = m; x.a_nb = a_nb; x.b_nb = b_nb; x.cnt_sat = cs;
    return x;
  endfunction

  // Queue the expected post-edge state, then let one clock edge happen.
  task automatic step(input exp_t x);
    q.push_back(x);
    @(posedge Clk);
    @(negedge Clk);
    #1;
  endtask

  task automatic set_id(logic v, logic [31:0] a, logic [31:0] b, logic [11:0] imm,
                        logic [4:0] opc, logic [3:0] rd, logic [3:0] rn, logic [3:0] rm,
                        logic [2:0] icmd, logic s);
    ID_Valid = v; ID_A = a; ID_B = b; ID_immed = imm; ID_Opcode = opc;
    ID_Rd_num = rd; ID_Rn_num = rn; ID_Rm_num = rm; ID_I_cmd = icmd; ID_S = s;
  endtask

  task automatic randomize_inputs();
    set_id(1'($urandom), $urandom, $urandom, 12'($urandom), 5'($urandom), 4'($urandom),
           4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom));
    WB_En = 1'($urandom); WB_Rd_num = 4'($urandom); WB_Data = $urandom;
  endtask

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      mon_x = q.pop_front();
      cmp_all(mon_x);
    end
  end

  rec_t zero_r, l1, hold_r;

  initial begin
    Rst_n = 1'b1; Stall = 1'b0; Flush = 1'b0;
    randomize_inputs();
    zero_r = mk(1'b0, 32'h0, 32'h0, 12'h0, 5'h0, 4'd0, 4'd0, 4'd0, 3'd0, 1'b0, 16'd0);

    // Asynchronous reset asserted between edges.
    #2 Rst_n = 1'b0;
    #1 cmp_all(mkx(zero_r, 32'h0, 32'h0, 16'd0));
    @(negedge Clk); #1;
    Rst_n = 1'b1;

    // Load, then bubble from ID_Valid=0, then reload.
    WB_En = 1'b0; WB_Rd_num = 4'd0; WB_Data = 32'h0;
    set_id(1'b1, 32'h11, 32'h22, 12'hABC, 5'h04, 4'd3, 4'd2, 4'd5, 3'd5, 1'b1);
    l1 = mk(1'b1, 32'h11, 32'h22, 12'hABC, 5'h04, 4'd3, 4'd2, 4'd5, 3'd5, 1'b1, 16'd0);
    step(mkx(l1, 32'h11, 32'h22, 16'd0));
    ID_Valid = 1'b0;
    step(mkx(zero_r, 32'h0, 32'h0, 16'd0));
    ID_Valid = 1'b1;
    step(mkx(l1, 32'h11, 32'h22, 16'd0));

    // Stall three cycles; WB to Rm=5 on the second.
    Stall = 1'b1;
    set_id(1'b1, 32'h55, 32'h66, 12'h321, 5'h09, 4'd8, 4'd5, 4'd2, 3'd1, 1'b0);
    hold_r = l1; hold_r.cnt = 16'd1;
    step(mkx(hold_r, 32'h11, 32'h22, 16'd1));
    WB_En = 1'b1; WB_Rd_num = 4'd5; WB_Data = 32'hBEEF;
    hold_r.b = 32'hBEEF; hold_r.cnt = 16'd2;
    step(mkx(hold_r, 32'h11, 32'hBEEF, 16'd2));
    WB_En = 1'b0;
    hold_r.cnt = 16'd3;
    step(mkx(hold_r, 32'h11, 32'hBEEF, 16'd3));

    // Flush with stall -> bubble, counter frozen; stall of a bubble: no refresh.
    Flush = 1'b1;
    hold_r = zero_r; hold_r.cnt = 16'd3;
    step(mkx(hold_r, 32'h0, 32'h0, 16'd3));
    Flush = 1'b0;
    WB_En = 1'b1; WB_Rd_num = 4'd0; WB_Data = 32'h77;
    step(mkx(hold_r, 32'h0, 32'h0, 16'd3));

    // Load with same-cycle WB bypass on Rn=Rm=7.
    Stall = 1'b0;
    set_id(1'b1, 32'h1, 32'h2, 12'hFFF, 5'h1F, 4'hF, 4'd7, 4'd7, 3'd7, 1'b0);
    WB_En = 1'b1; WB_Rd_num = 4'd7; WB_Data = 32'h99;
    hold_r = mk(1'b1, 32'h99, 32'h99, 12'hFFF, 5'h1F, 4'hF, 4'd7, 4'd7, 3'd7, 1'b0, 16'd3);
    step(mkx(hold_r, 32'h1, 32'h2, 16'd3));

    // Stall with WB to 7 refreshes both operands, then hold long enough to saturate.
    Stall = 1'b1;
    set_id(1'b1, 32'hAAAA, 32'hBBBB, 12'h0, 5'h02, 4'd1, 4'd1, 4'd1, 3'd0, 1'b1);
    WB_Data = 32'h1234;
    hold_r.a = 32'h1234; hold_r.b = 32'h1234; hold_r.cnt = 16'd4;
    step(mkx(hold_r, 32'h1234, 32'h1234, 16'd4));
    WB_En = 1'b0;
    for (int i = 5; i <= 10; i++) begin
      hold_r.cnt = 16'(i);
      step(mkx(hold_r, 32'h1234, 32'h1234, (i > 7) ? 16'd7 : 16'(i)));
    end

    // Reset mid-stall with random inputs discards everything at once.
    randomize_inputs();
    Stall = 1'b1;
    #1 Rst_n = 1'b0;
    #1 cmp_all(mkx(zero_r, 32'h0, 32'h0, 16'd0));
    @(negedge Clk); #1;
    Rst_n = 1'b1;

    // Normal load after reset; WB to an unrelated register.
    Stall = 1'b0; Flush = 1'b0;
    set_id(1'b1, 32'hCAFE, 32'hF00D, 12'h123, 5'h0A, 4'd1, 4'd3, 4'd4, 3'd2, 1'b1);
    WB_En = 1'b1; WB_Rd_num = 4'd9; WB_Data = 32'h5555;
    hold_r = mk(1'b1, 32'hCAFE, 32'hF00D, 12'h123, 5'h0A, 4'd1, 4'd3, 4'd4, 3'd2, 1'b1, 16'd0);
    step(mkx(hold_r, 32'hCAFE, 32'hF00D, 16'd0));

    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      @(negedge Clk);
    end
    chk("drain", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
